// File: rtl/view_controller.sv
// view_controller: turns pan/zoom/iteration requests into a working view of
// the Mandelbrot plane. When the working view changes and the renderer is
// idle, it publishes a consistent snapshot and launches one frame through a
// start/busy handshake.
module view_controller #(
  parameter int                        COORD_W      = 32,
  parameter logic signed [COORD_W-1:0] INIT_CX      = -32'sd134217728,
  parameter logic signed [COORD_W-1:0] INIT_CY      = 32'sd0,
  parameter logic signed [COORD_W-1:0] INIT_STEP    = 32'sd2097152,
  parameter int                        ZOOM_MAX     = 21,
  parameter int                        PAN_PIX_LOG2 = 2,
  parameter int                        ITERS_W      = 13,
  parameter int                        ITERS_INIT   = 256,
  parameter int                        ITERS_MIN    = 16,
  parameter int                        ITERS_MAX    = 4096,
  parameter int                        ITERS_STEP   = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      move_up,
  input  logic                      move_down,
  input  logic                      move_left,
  input  logic                      move_right,
  input  logic                      move_tick,
  input  logic                      zoom_in_pulse,
  input  logic                      zoom_out_pulse,
  input  logic                      iters_inc_pulse,
  input  logic                      iters_dec_pulse,
  input  logic                      zoom_reset_pulse,
  input  logic                      render_busy,
  output logic                      render_start,
  output logic signed [COORD_W-1:0] view_cx,
  output logic signed [COORD_W-1:0] view_cy,
  output logic signed [COORD_W-1:0] view_step,
  output logic [ITERS_W-1:0]        view_iters,
  output logic [4:0]                view_zoom,
  output logic                      dirty
);

  localparam logic [1:0] ST_IDLE     = 2'd0;
  localparam logic [1:0] ST_LAUNCH   = 2'd1;
  localparam logic [1:0] ST_WAIT_ACK = 2'd2;
  localparam logic [1:0] ST_BUSY     = 2'd3;

  localparam logic [4:0]         ZOOM_MAX_C   = 5'(ZOOM_MAX);
  localparam logic [ITERS_W-1:0] ITERS_INIT_C = ITERS_W'(ITERS_INIT);
  localparam logic [ITERS_W-1:0] ITERS_MIN_C  = ITERS_W'(ITERS_MIN);
  localparam logic [ITERS_W-1:0] ITERS_MAX_C  = ITERS_W'(ITERS_MAX);
  localparam logic [ITERS_W-1:0] ITERS_STEP_C = ITERS_W'(ITERS_STEP);

  localparam logic signed [COORD_W-1:0] COORD_MAX_C = {1'b0, {(COORD_W-1){1'b1}}};
  localparam logic signed [COORD_W-1:0] COORD_MIN_C = {1'b1, {(COORD_W-1){1'b0}}};

  // Signed add that clamps to the representable range instead of wrapping.
  function automatic logic signed [COORD_W-1:0] sat_add(
    input logic signed [COORD_W-1:0] a,
    input logic signed [COORD_W-1:0] b
  );
    logic [COORD_W:0] sum;
    sum = {a[COORD_W-1], a} + {b[COORD_W-1], b};
    if (sum[COORD_W] != sum[COORD_W-1]) begin
      if (sum[COORD_W]) sat_add = COORD_MIN_C;
      else              sat_add = COORD_MAX_C;
    end else begin
      sat_add = sum[COORD_W-1:0];
    end
  endfunction

  // Iteration count plus one step, clamped at the upper bound.
  function automatic logic [ITERS_W-1:0] iters_up(input logic [ITERS_W-1:0] v);
    logic [ITERS_W:0] s;
    s = {1'b0, v} + {1'b0, ITERS_STEP_C};
    if (s > {1'b0, ITERS_MAX_C}) iters_up = ITERS_MAX_C;
    else                         iters_up = s[ITERS_W-1:0];
  endfunction

  // Iteration count minus one step, clamped at the lower bound.
  function automatic logic [ITERS_W-1:0] iters_down(input logic [ITERS_W-1:0] v);
    if ({1'b0, v} < ({1'b0, ITERS_MIN_C} + {1'b0, ITERS_STEP_C})) iters_down = ITERS_MIN_C;
    else                                                          iters_down = v - ITERS_STEP_C;
  endfunction

  logic signed [COORD_W-1:0] wcx_r, wcy_r;
  logic [4:0]                wzoom_r;
  logic [ITERS_W-1:0]        witers_r;
  logic                      dirty_r;
  logic [1:0]                state_r, state_n;

  logic signed [COORD_W-1:0] cx_n, cy_n;
  logic [4:0]                zoom_n;
  logic [ITERS_W-1:0]        iters_n;
  logic [COORD_W-1:0]        step_s;
  logic signed [COORD_W-1:0] pan_delta_s, dx_s, dy_s;
  logic                      changed_s, launch_s;

  // Step and pan delta always come from the current (pre-update) zoom level.
  assign step_s      = $unsigned(INIT_STEP) >> wzoom_r;
  assign pan_delta_s = $signed(step_s << PAN_PIX_LOG2);

  // Per-axis pan offsets; opposite directions held together cancel.
  always_comb begin
    dx_s = {COORD_W{1'b0}};
    dy_s = {COORD_W{1'b0}};
    if (move_right && !move_left)      dx_s = pan_delta_s;
    else if (move_left && !move_right) dx_s = -pan_delta_s;
    else                               dx_s = {COORD_W{1'b0}};
    if (move_down && !move_up)         dy_s = pan_delta_s;
    else if (move_up && !move_down)    dy_s = -pan_delta_s;
    else                               dy_s = {COORD_W{1'b0}};
  end

  // Next working view: zoom reset overrides everything, otherwise zoom, pan
  // and iteration requests all apply in the same cycle.
  always_comb begin
    cx_n    = wcx_r;
    cy_n    = wcy_r;
    zoom_n  = wzoom_r;
    iters_n = witers_r;
    if (zoom_reset_pulse) begin
      cx_n    = INIT_CX;
      cy_n    = INIT_CY;
      zoom_n  = 5'd0;
      iters_n = ITERS_INIT_C;
    end else begin
      if (zoom_in_pulse && !zoom_out_pulse) begin
        if (wzoom_r < ZOOM_MAX_C) zoom_n = wzoom_r + 5'd1;
        else                      zoom_n = ZOOM_MAX_C;
      end else if (zoom_out_pulse && !zoom_in_pulse) begin
        if (wzoom_r != 5'd0) zoom_n = wzoom_r - 5'd1;
        else                 zoom_n = 5'd0;
      end else begin
        zoom_n = wzoom_r;
      end

      if (move_tick) begin
        cx_n = sat_add(wcx_r, dx_s);
        cy_n = sat_add(wcy_r, dy_s);
      end else begin
        cx_n = wcx_r;
        cy_n = wcy_r;
      end

      if (iters_inc_pulse && !iters_dec_pulse)      iters_n = iters_up(witers_r);
      else if (iters_dec_pulse && !iters_inc_pulse) iters_n = iters_down(witers_r);
      else                                          iters_n = witers_r;
    end
  end

  // A request only marks the view dirty if it really moved a register.
  assign changed_s = (cx_n != wcx_r) || (cy_n != wcy_r) ||
                     (zoom_n != wzoom_r) || (iters_n != witers_r);
  assign launch_s  = (state_r == ST_IDLE) && dirty_r && !render_busy;
  assign dirty     = dirty_r;

  // Frame handshake sequencing: launch, wait for busy to rise, then fall.
  always_comb begin
    state_n = state_r;
    case (state_r)
      ST_IDLE: begin
        if (launch_s) state_n = ST_LAUNCH;
        else          state_n = ST_IDLE;
      end
      ST_LAUNCH: state_n = ST_WAIT_ACK;
      ST_WAIT_ACK: begin
        if (render_busy) state_n = ST_BUSY;
        else             state_n = ST_WAIT_ACK;
      end
      ST_BUSY: begin
        if (!render_busy) state_n = ST_IDLE;
        else              state_n = ST_BUSY;
      end
      default: state_n = ST_IDLE;
    endcase
  end

  // Working view registers, updated every cycle from the request logic.
  always_ff @(posedge clk) begin
    if (rst) begin
      wcx_r    <= INIT_CX;
      wcy_r    <= INIT_CY;
      wzoom_r  <= 5'd0;
      witers_r <= ITERS_INIT_C;
    end else begin
      wcx_r    <= cx_n;
      wcy_r    <= cy_n;
      wzoom_r  <= zoom_n;
      witers_r <= iters_n;
    end
  end

  // FSM state, dirty tracking, launch strobe and published snapshot.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r      <= ST_IDLE;
      dirty_r      <= 1'b1;
      render_start <= 1'b0;
      view_cx      <= INIT_CX;
      view_cy      <= INIT_CY;
      view_step    <= INIT_STEP;
      view_iters   <= ITERS_INIT_C;
      view_zoom    <= 5'd0;
    end else begin
      state_r      <= state_n;
      render_start <= launch_s;
      if (launch_s) begin
        // Snapshot is taken before this cycle's change lands, so a change
        // arriving now keeps the view dirty for a follow-up frame.
        dirty_r    <= changed_s;
        view_cx    <= wcx_r;
        view_cy    <= wcy_r;
        view_step  <= $signed(step_s);
        view_iters <= witers_r;
        view_zoom  <= wzoom_r;
      end else begin
        dirty_r    <= dirty_r | changed_s;
        view_cx    <= view_cx;
        view_cy    <= view_cy;
        view_step  <= view_step;
        view_iters <= view_iters;
        view_zoom  <= view_zoom;
      end
    end
  end

endmodule

// File: tb/tb_view_controller.sv
// Self-checking bench for view_controller: directed vector table, multi-cycle
// corner sequences, then randomized requests against a view-level model.
module tb_view_controller;

  logic clk = 1'b0;
  logic rst;
  logic move_up, move_down, move_left, move_right, move_tick;
  logic zoom_in_pulse, zoom_out_pulse, iters_inc_pulse, iters_dec_pulse, zoom_reset_pulse;
  logic render_busy;
  logic render_start;
  logic signed [31:0] view_cx, view_cy, view_step;
  logic [12:0] view_iters;
  logic [4:0]  view_zoom;
  logic dirty;

  int checks = 0;
  int failures = 0;

  localparam longint DEF_CX = -64'sd134217728;

  view_controller dut (
    .clk(clk), .rst(rst),
    .move_up(move_up), .move_down(move_down), .move_left(move_left), .move_right(move_right),
    .move_tick(move_tick),
    .zoom_in_pulse(zoom_in_pulse), .zoom_out_pulse(zoom_out_pulse),
    .iters_inc_pulse(iters_inc_pulse), .iters_dec_pulse(iters_dec_pulse),
    .zoom_reset_pulse(zoom_reset_pulse),
    .render_busy(render_busy), .render_start(render_start),
    .view_cx(view_cx), .view_cy(view_cy), .view_step(view_step),
    .view_iters(view_iters), .view_zoom(view_zoom), .dirty(dirty)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    bit zi, zo, ii, id, zr, up, dn, lf, rt, tk;
    bit launch;
    longint cx, cy;
    int zoom, iters;
  } vec_t;

  typedef struct packed {
    longint cx, cy;
    int zoom, iters;
  } view_t;

  function automatic vec_t mk(input bit zi, zo, ii, id, zr, up, dn, lf, rt, tk, launch,
                              input longint cx, cy, input int zoom, iters);
    vec_t v;
    v.zi = zi; v.zo = zo; v.ii = ii; v.id = id; v.zr = zr;
    v.up = up; v.dn = dn; v.lf = lf; v.rt = rt; v.tk = tk;
    v.launch = launch; v.cx = cx; v.cy = cy; v.zoom = zoom; v.iters = iters;
    return v;
  endfunction

  task automatic chk(input string name, input logic signed [63:0] act, input logic signed [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic check_view(input string tag, input longint cx, cy, input int zoom, iters);
    chk({tag, ".cx"}, view_cx, cx);
    chk({tag, ".cy"}, view_cy, cy);
    chk({tag, ".zoom"}, view_zoom, zoom);
    chk({tag, ".step"}, view_step, 2097152 >> zoom);
    chk({tag, ".iters"}, view_iters, iters);
  endtask

  task automatic clear_req();
    move_up = 1'b0; move_down = 1'b0; move_left = 1'b0; move_right = 1'b0; move_tick = 1'b0;
    zoom_in_pulse = 1'b0; zoom_out_pulse = 1'b0; iters_inc_pulse = 1'b0; iters_dec_pulse = 1'b0;
    zoom_reset_pulse = 1'b0;
  endtask

  task automatic wait_start(input int bound, output bit seen);
    seen = 1'b0;
    for (int i = 0; i < bound; i++) begin
      @(negedge clk);
      if (render_start) begin
        seen = 1'b1;
        break;
      end
    end
  endtask

  // Called at the negedge where render_start is seen: run a short frame.
  task automatic ack(input string tag);
    render_busy = 1'b1;
    @(negedge clk);
    chk({tag, ".pulse_width"}, render_start, 0);
    @(negedge clk);
    render_busy = 1'b0;
    @(negedge clk);
    @(negedge clk);
  endtask

  task automatic count_starts(input int cycles, output int n);
    n = 0;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      if (render_start) n++;
    end
  endtask

  task automatic apply_vec(input vec_t v, input string tag);
    @(negedge clk);
    zoom_in_pulse = v.zi; zoom_out_pulse = v.zo; iters_inc_pulse = v.ii; iters_dec_pulse = v.id;
    zoom_reset_pulse = v.zr; move_up = v.up; move_down = v.dn; move_left = v.lf;
    move_right = v.rt; move_tick = v.tk;
    @(negedge clk);
    clear_req();
    chk({tag, ".early"}, render_start, 0);
    @(negedge clk);
    chk({tag, ".start"}, render_start, v.launch);
    check_view(tag, v.cx, v.cy, v.zoom, v.iters);
    if (render_start) ack(tag);
    else repeat (3) @(negedge clk);
    chk({tag, ".dirty"}, dirty, 0);
  endtask

  // View-level reference: the request rules computed with plain arithmetic.
  function automatic longint clamp32(input longint x);
    if (x > 64'sd2147483647) return 64'sd2147483647;
    if (x < -64'sd2147483648) return -64'sd2147483648;
    return x;
  endfunction

  function automatic view_t def_view();
    view_t v;
    v.cx = DEF_CX; v.cy = 0; v.zoom = 0; v.iters = 256;
    return v;
  endfunction

  function automatic view_t next_view(input view_t v, input bit zr, zi, zo, ii, id, tk, up, dn, lf, rt);
    view_t n;
    longint d;
    if (zr) return def_view();
    n = v;
    if (zi && !zo) n.zoom = (v.zoom < 21) ? v.zoom + 1 : 21;
    else if (zo && !zi) n.zoom = (v.zoom > 0) ? v.zoom - 1 : 0;
    if (tk) begin
      d = longint'(2097152 >> v.zoom) * 4;
      n.cx = clamp32(v.cx + (rt ? d : 0) - (lf ? d : 0));
      n.cy = clamp32(v.cy + (dn ? d : 0) - (up ? d : 0));
    end
    if (ii && !id) n.iters = (v.iters + 16 > 4096) ? 4096 : v.iters + 16;
    else if (id && !ii) n.iters = (v.iters - 16 < 16) ? 16 : v.iters - 16;
    return n;
  endfunction

  vec_t vt[17];

  initial begin
    bit seen;
    int n;
    view_t m_w, m_pub, nv;
    bit m_dirty, m_start, launch;
    int m_phase;          // 0 free, 1 launched/awaiting busy, 2 awaiting busy fall
    bit r_pending;
    int r_wait, r_left;

    vt[0]  = mk(1,0,0,0,0, 0,0,0,0,0, 1, DEF_CX, 0, 1, 256);
    vt[1]  = mk(1,0,0,0,0, 0,0,0,0,0, 1, DEF_CX, 0, 2, 256);
    vt[2]  = mk(1,0,0,0,0, 0,0,0,0,0, 1, DEF_CX, 0, 3, 256);
    vt[3]  = mk(1,1,0,0,0, 0,0,0,0,0, 0, DEF_CX, 0, 3, 256);
    vt[4]  = mk(1,0,0,0,1, 0,0,0,0,0, 1, DEF_CX, 0, 0, 256);
    vt[5]  = mk(0,0,0,0,0, 0,0,0,1,1, 1, -125829120, 0, 0, 256);
    vt[6]  = mk(0,0,0,0,0, 0,0,1,1,1, 0, -125829120, 0, 0, 256);
    vt[7]  = mk(0,0,0,0,0, 0,0,0,1,0, 0, -125829120, 0, 0, 256);
    vt[8]  = mk(0,0,0,0,0, 1,0,0,0,1, 1, -125829120, -8388608, 0, 256);
    vt[9]  = mk(0,0,0,0,0, 0,1,1,0,1, 1, DEF_CX, 0, 0, 256);
    vt[10] = mk(0,0,1,0,0, 0,0,0,0,0, 1, DEF_CX, 0, 0, 272);
    vt[11] = mk(0,0,1,1,0, 0,0,0,0,0, 0, DEF_CX, 0, 0, 272);
    vt[12] = mk(0,0,0,1,0, 0,0,0,0,0, 1, DEF_CX, 0, 0, 256);
    vt[13] = mk(0,1,0,0,0, 0,0,0,0,0, 0, DEF_CX, 0, 0, 256);
    vt[14] = mk(1,0,1,0,0, 0,0,0,1,1, 1, -125829120, 0, 1, 272);
    vt[15] = mk(0,0,0,0,1, 0,0,0,0,0, 1, DEF_CX, 0, 0, 256);
    vt[16] = mk(0,0,0,0,1, 0,0,0,0,0, 0, DEF_CX, 0, 0, 256);

    // Reset release: first frame launches on its own.
    rst = 1'b1; render_busy = 1'b0; clear_req();
    repeat (3) @(negedge clk);
    chk("rst.start", render_start, 0);
    chk("rst.dirty", dirty, 1);
    check_view("rst", DEF_CX, 0, 0, 256);
    rst = 1'b0;
    @(negedge clk);
    chk("rst.launch", render_start, 1);
    check_view("rst_launch", DEF_CX, 0, 0, 256);
    if (render_start) ack("rst");
    chk("rst.dirty_after", dirty, 0);

    // Directed vectors.
    for (int i = 0; i < 17; i++) apply_vec(vt[i], $sformatf("vec%0d", i));

    // Zoom up to the limit; one past the limit must not launch.
    for (int i = 1; i <= 22; i++)
      apply_vec(mk(1,0,0,0,0, 0,0,0,0,0, (i <= 21), DEF_CX, 0, (i <= 21) ? i : 21, 256),
                $sformatf("zoom%0d", i));
    apply_vec(vt[15], "zoom_restore");

    // Requests during a render coalesce into exactly one follow-up frame.
    @(negedge clk); zoom_in_pulse = 1'b1;
    @(negedge clk); clear_req();
    wait_start(4, seen);
    chk("coal.first", seen, 1);
    chk("coal.first_zoom", view_zoom, 1);
    render_busy = 1'b1;
    n = 0;
    for (int k = 0; k < 7; k++) begin
      @(negedge clk);
      if (render_start) n++;
      clear_req();
      if (k < 5) iters_inc_pulse = 1'b1;
      else       zoom_in_pulse = 1'b1;
    end
    @(negedge clk);
    if (render_start) n++;
    clear_req();
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      if (render_start) n++;
    end
    chk("coal.busy_starts", n, 0);
    chk("coal.dirty_busy", dirty, 1);
    render_busy = 1'b0;
    wait_start(5, seen);
    chk("coal.follow", seen, 1);
    check_view("coal", DEF_CX, 0, 3, 336);
    if (seen) ack("coal");
    count_starts(8, n);
    chk("coal.extra_starts", n, 0);
    apply_vec(vt[15], "coal_restore");

    // Pan toward the negative Y limit far enough that it would wrap.
    render_busy = 1'b1;
    @(negedge clk); zoom_in_pulse = 1'b1;
    @(negedge clk); clear_req(); move_down = 1'b1; move_tick = 1'b1;
    @(negedge clk); clear_req(); zoom_out_pulse = 1'b1;
    @(negedge clk); clear_req(); move_up = 1'b1; move_tick = 1'b1;
    repeat (300) @(negedge clk);
    clear_req();
    @(negedge clk);
    chk("sat.no_start_busy", render_start, 0);
    render_busy = 1'b0;
    wait_start(4, seen);
    chk("sat.launch", seen, 1);
    check_view("sat", DEF_CX, -64'sd2147483648, 0, 256);
    if (seen) ack("sat");
    apply_vec(vt[15], "sat_restore");

    // Iterations floor: a decrement at the minimum is not a change.
    render_busy = 1'b1;
    @(negedge clk); iters_dec_pulse = 1'b1;
    repeat (20) @(negedge clk);
    clear_req();
    @(negedge clk);
    render_busy = 1'b0;
    wait_start(4, seen);
    chk("floor.launch", seen, 1);
    check_view("floor", DEF_CX, 0, 0, 16);
    if (seen) ack("floor");
    chk("floor.dirty_before", dirty, 0);
    @(negedge clk); iters_dec_pulse = 1'b1;
    @(negedge clk); clear_req();
    chk("floor.dirty_after", dirty, 0);
    count_starts(5, n);
    chk("floor.starts", n, 0);
    chk("floor.iters", view_iters, 16);
    apply_vec(vt[15], "floor_restore");

    // Reset in the middle of a render: wait for busy to drop, relaunch defaults.
    @(negedge clk); zoom_in_pulse = 1'b1;
    @(negedge clk); clear_req();
    wait_start(4, seen);
    chk("midrst.first", seen, 1);
    render_busy = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("midrst.dirty", dirty, 1);
    chk("midrst.start", render_start, 0);
    check_view("midrst", DEF_CX, 0, 0, 256);
    count_starts(3, n);
    chk("midrst.starts_busy", n, 0);
    render_busy = 1'b0;
    wait_start(4, seen);
    chk("midrst.relaunch", seen, 1);
    check_view("midrst_launch", DEF_CX, 0, 0, 256);
    if (seen) ack("midrst");

    // Randomized requests against the view-level model with an emulated renderer.
    rst = 1'b1; render_busy = 1'b0; clear_req();
    @(negedge clk);
    rst = 1'b0;
    m_w = def_view(); m_pub = def_view();
    m_dirty = 1'b1; m_start = 1'b0; m_phase = 0;
    r_pending = 1'b0; r_wait = 0; r_left = 0;
    for (int c = 0; c < 4000; c++) begin
      chk("rnd.start", render_start, m_start);
      chk("rnd.dirty", dirty, m_dirty);
      chk("rnd.cx", view_cx, m_pub.cx);
      chk("rnd.cy", view_cy, m_pub.cy);
      chk("rnd.zoom", view_zoom, m_pub.zoom);
      chk("rnd.step", view_step, 2097152 >> m_pub.zoom);
      chk("rnd.iters", view_iters, m_pub.iters);

      if (render_start) begin
        r_pending = 1'b1;
        r_wait = $urandom_range(0, 3);
      end
      if (r_pending) begin
        if (r_wait == 0) begin
          render_busy = 1'b1;
          r_left = $urandom_range(2, 8);
          r_pending = 1'b0;
        end else begin
          r_wait--;
        end
      end else if (render_busy) begin
        r_left--;
        if (r_left <= 0) render_busy = 1'b0;
      end

      zoom_in_pulse    = ($urandom_range(0, 7) == 0);
      zoom_out_pulse   = ($urandom_range(0, 7) == 0);
      iters_inc_pulse  = ($urandom_range(0, 7) == 0);
      iters_dec_pulse  = ($urandom_range(0, 7) == 0);
      zoom_reset_pulse = ($urandom_range(0, 63) == 0);
      move_up          = $urandom_range(0, 1);
      move_down        = $urandom_range(0, 1);
      move_left        = $urandom_range(0, 1);
      move_right       = $urandom_range(0, 1);
      move_tick        = ($urandom_range(0, 2) == 0);

      launch = (m_phase == 0) && m_dirty && !render_busy;
      nv = next_view(m_w, zoom_reset_pulse, zoom_in_pulse, zoom_out_pulse, iters_inc_pulse,
                     iters_dec_pulse, move_tick, move_up, move_down, move_left, move_right);
      if (launch) begin
        m_pub = m_w;
        m_dirty = (nv != m_w);
        m_phase = 1;
      end else begin
        m_dirty = m_dirty | (nv != m_w);
        if (m_phase == 1 && render_busy) m_phase = 2;
        else if (m_phase == 2 && !render_busy) m_phase = 0;
      end
      m_start = launch;
      m_w = nv;
      @(negedge clk);
    end
    clear_req();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/view_controller.md
# view_controller

Sequencer between the debounced joystick front end and the Mandelbrot render engine. It turns pan, zoom, iteration and zoom-reset requests into a working view (center, per-pixel step, max iterations). Whenever the working view has changed and the renderer is idle, it publishes a consistent snapshot of that view and launches a frame through a start/busy handshake.

## Interface
- COORD_W, 32: signed fixed-point width of coordinates and step (Q4.28).
- INIT_CX, -134217728: reset center X (-0.5).
- INIT_CY, 0: reset center Y.
- INIT_STEP, 2097152: step per pixel at zoom level 0 (1/128).
- ZOOM_MAX, 21: maximum zoom level. Step = INIT_STEP >> zoom_level, and is never 0.
- PAN_PIX_LOG2, 2: pan delta per move tick = step << PAN_PIX_LOG2.
- ITERS_W, 13: width of max_iters.
- ITERS_INIT, 256; ITERS_MIN, 16; ITERS_MAX, 4096; ITERS_STEP, 16.
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- move_up, move_down, move_left, move_right  in  1 each  pan direction levels.
- move_tick  in  1  pan repeat strobe.
- zoom_in_pulse, zoom_out_pulse  in  1 each  one-cycle zoom requests.
- iters_inc_pulse, iters_dec_pulse  in  1 each  one-cycle iteration requests.
- zoom_reset_pulse  in  1  restore the reset view.
- render_busy  in  1  renderer is drawing a frame.
- render_start  out  1  one-cycle frame launch.
- view_cx, view_cy  out  COORD_W  published center, signed.
- view_step  out  COORD_W  published step per pixel.
- view_iters  out  ITERS_W  published max iterations.
- view_zoom  out  5  published zoom level.
- dirty  out  1  working view differs from the published view.

## Operation
- Working registers: wcx, wcy, wzoom, witers. Published outputs change only in the cycle that render_start is asserted.
- Priority per cycle, evaluated in this order:
  - zoom_reset_pulse: restore all working defaults. Ignore every other request that cycle.
  - Zoom: zoom_in and zoom_out together means no zoom change. zoom_in increments wzoom, saturating at ZOOM_MAX. zoom_out decrements it, saturating at 0.
  - Pan: applies only on move_tick, using the step from the pre-update wzoom.
    - move_right adds the pan delta to wcx; move_left subtracts it. Both together cancel.
    - move_up subtracts the pan delta from wcy (screen-down is +Y); move_down adds it. Both together cancel.
    - Signed add saturates at ±(2^(COORD_W-1)) limits; it never wraps.
  - Iterations: inc and dec together means no change. Otherwise witers ±= ITERS_STEP, clamped to [ITERS_MIN, ITERS_MAX].
  - Pan, zoom and iteration updates in the same cycle all apply.
- dirty sets only when a working register actually changes value. A request already at its bound leaves dirty untouched.
- FSM states:
  - IDLE: if dirty and !render_busy, go to LAUNCH.
  - LAUNCH, one cycle:
    - Copy working registers to the view_* outputs.
    - Assert render_start and clear dirty. A change arriving in this same cycle sets dirty again.
    - Go to WAIT_ACK.
  - WAIT_ACK: go to BUSY when render_busy = 1.
  - BUSY: go to IDLE when render_busy = 0.
- Requests are accepted in every state. Changes made during a render set dirty, coalesce, and launch exactly one follow-up frame.

## Timing
- Reset values:
  - Working registers and view_* take their INIT values; view_zoom = 0; view_step = INIT_STEP.
  - render_start = 0; state = IDLE.
  - dirty = 1, so the first frame launches automatically.
- Latency, with a request in cycle N:
  - Working registers and dirty update at edge N+1.
  - If IDLE and not busy: render_start = 1 and the new view_* are valid in cycle N+2.
- render_start is high for exactly one cycle per LAUNCH. There is no relaunch until render_busy has risen and then fallen.
- If render_busy never rises, the block stays in WAIT_ACK; no timeout.
- rst asserted mid-render: state goes to IDLE and dirty = 1. The controller waits for render_busy = 0, then relaunches with the default view.

## Test plan
- Reset release with render_busy = 0:
  - render_start pulses in cycle 2.
  - view_cx = -134217728, view_cy = 0, view_step = 2097152, view_iters = 256.
- zoom_in ×3, renderer idle: view_zoom = 3 and view_step = 262144. One launch per pulse. A 22nd zoom_in at level 21 produces no launch.
- move_right + move_tick at zoom 0: view_cx increases by 8388608. Adding move_left in the same cycle gives no change and no launch.
- During BUSY, apply 5 iters_inc pulses and 2 zoom_in pulses:
  - No launch while busy.
  - Exactly one launch after render_busy falls, with view_iters = 336 and view_zoom = +2.
- Saturation:
  - Pan wcy toward the negative limit: it stops at -2147483648 with no wrap.
  - iters_dec from 16: no change and dirty stays 0.
- zoom_reset_pulse with zoom_in in the same cycle: defaults are restored, zoom_in is ignored, and one launch follows.
